adc_acq_engine: RTL

- Parametrised successor to the current fixed 4-SCK/8-SDO ADC acquisition block.
- Drives N_ADC serial SAR ADCs with a shared CNV_n line, one SCK per ADC, and LANES SDO lanes per ADC.
- Runs a programmed number of conversions, deserialises and packs samples into OUT_W-bit words, and writes them to the acquisition FIFO that feeds the DDR3 write path.
- Adds per-conversion pacing, abort, a debug pattern mode and sticky overflow detection.

---
 rtl/adc_acq_pkg.sv | 28 ++
 rtl/adc_lane_deser.sv | 43 ++++
 rtl/adc_acq_engine.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_acq_pkg.sv
// Shared types and derived-width helpers for the ADC acquisition engine.
package adc_acq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNV,
        WAIT,
        SHIFT,
        STORE,
        GAP
    } state_e;

    // Shift cycles per conversion.
    function automatic int unsigned calc_b(input int unsigned sample_w, input int unsigned lanes);
        return sample_w / lanes;
    endfunction

    // Bits produced by one conversion across all ADCs.
    function automatic int unsigned calc_cw(input int unsigned n_adc, input int unsigned sample_w);
        return n_adc * sample_w;
    endfunction

    // Conversions packed into one output word.
    function automatic int unsigned calc_k(input int unsigned out_w, input int unsigned cw);
        return out_w / cw;
    endfunction

endpackage

// File: rtl/adc_lane_deser.sv
// Per-ADC deserialiser: merges LANES MSB-first interleaved SDO lanes into one sample.
module adc_lane_deser
    import adc_acq_pkg::*;
#(
    parameter int unsigned LANES    = 2,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift_i,
    input  logic [LANES-1:0]    sdo_i,
    output logic [SAMPLE_W-1:0] sample_o
);

    logic [LANES-1:0]    ins_c;
    logic [SAMPLE_W-1:0] sr_q;
    logic [SAMPLE_W-1:0] sr_d;

    // Lane 0 carries the more significant bit of each shift group.
    always_comb begin
        ins_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            ins_c[LANES-1-l] = sdo_i[l];
        end
    end

    if (SAMPLE_W == LANES) begin : g_single
        assign sr_d = shift_i ? ins_c : sr_q;
    end else begin : g_multi
        assign sr_d = shift_i ? {sr_q[SAMPLE_W-LANES-1:0], ins_c} : sr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sample_o = sr_q;

endmodule

// File: rtl/adc_acq_engine.sv
// Multi-ADC SAR acquisition: paced conversions, serial readout, word packing into the acquisition FIFO.
module adc_acq_engine
    import adc_acq_pkg::*;
#(
    parameter int unsigned N_ADC    = 4,
    parameter int unsigned LANES    = 2,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned OUT_W    = 128,
    parameter int unsigned SCK_HALF = 2,
    parameter int unsigned CNV_CYC  = 2,
    parameter int unsigned CONV_CYC = 60
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_calib_done,
    input  logic                     i_debug_en,
    input  logic [31:0]              i_samples_count,
    input  logic [15:0]              i_period,
    input  logic                     i_full,
    output logic [OUT_W-1:0]         o_data,
    output logic                     o_rdy,
    output logic                     o_finished,
    output logic                     o_busy,
    output logic                     o_overflow,
    output logic                     o_adc_cnv_n,
    output logic [N_ADC-1:0]         o_adc_sck,
    input  logic [N_ADC*LANES-1:0]   i_adc_sdo
);

    localparam int unsigned B       = calc_b(SAMPLE_W, LANES);
    localparam int unsigned CW      = calc_cw(N_ADC, SAMPLE_W);
    localparam int unsigned K       = calc_k(OUT_W, CW);
    localparam int unsigned BIT_W   = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned SLOT_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned TMR_W   = 16;
    // Natural CNV-to-CNV spacing: CNV + WAIT + SHIFT + STORE + one GAP cycle.
    localparam int unsigned MIN_LEN = CNV_CYC + CONV_CYC + 2 * SCK_HALF * B + 2;

    if ((OUT_W % CW) != 0) begin : g_bad_out_w
        $error("OUT_W must be a multiple of N_ADC*SAMPLE_W");
    end
    if ((SAMPLE_W % LANES) != 0) begin : g_bad_lanes
        $error("SAMPLE_W must be a multiple of LANES");
    end

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [15:0]         per_q, per_d;
    logic [15:0]         period_q, period_d;
    logic [31:0]         rem_q, rem_d;
    logic [31:0]         idx_q, idx_d;
    logic [OUT_W-1:0]    pack_q, pack_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                dbg_q, dbg_d;
    logic [OUT_W-1:0]    data_q, data_d;
    logic                rdy_q, rdy_d;
    logic                fin_q, fin_d;
    logic                ovf_q, ovf_d;
    logic                busy_q;
    logic                cnv_n_q;
    logic [N_ADC-1:0]    sck_q;

    logic                shift_c;
    logic [CW-1:0]       conv_c;
    logic [OUT_W-1:0]    word_c;
    logic [15:0]         target_c;
    logic                emit_c;
    logic [SAMPLE_W-1:0] adc_sample [N_ADC];

    assign shift_c = (state_q == SHIFT) && (tmr_q == '0);

    for (genvar a = 0; a < N_ADC; a++) begin : g_deser
        adc_lane_deser #(
            .LANES    (LANES),
            .SAMPLE_W (SAMPLE_W)
        ) u_deser (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_i  (shift_c),
            .sdo_i    (i_adc_sdo[a*LANES +: LANES]),
            .sample_o (adc_sample[a])
        );
    end

    // Conversion payload: real samples or the debug ramp.
    always_comb begin
        conv_c = '0;
        for (int unsigned a = 0; a < N_ADC; a++) begin
            conv_c[a*SAMPLE_W +: SAMPLE_W] = dbg_q ? SAMPLE_W'(idx_q + 32'(a)) : adc_sample[a];
        end
    end

    always_comb begin
        word_c = pack_q;
        for (int unsigned k = 0; k < K; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                word_c[k*CW +: CW] = conv_c;
            end
        end
    end

    assign target_c = (period_q > 16'(MIN_LEN)) ? period_q : 16'(MIN_LEN);
    assign emit_c   = (slot_q == SLOT_W'(K - 1)) || (rem_q == 32'd1);

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bit_d    = bit_q;
        per_d    = (per_q == 16'hFFFF) ? per_q : per_q + 16'd1;
        period_d = period_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        pack_d   = pack_q;
        slot_d   = slot_q;
        dbg_d    = dbg_q;
        data_d   = data_q;
        rdy_d    = 1'b0;
        fin_d    = 1'b0;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (i_start && i_calib_done) begin
                    rem_d    = i_samples_count;
                    period_d = i_period;
                    dbg_d    = i_debug_en;
                    ovf_d    = 1'b0;
                    pack_d   = '0;
                    slot_d   = '0;
                    idx_d    = '0;
                    tmr_d    = '0;
                    per_d    = 16'd1;
                    if (i_samples_count == 32'd0) begin
                        fin_d = 1'b1;
                    end else begin
                        state_d = CNV;
                    end
                end
            end
            CNV: begin
                if (tmr_q == TMR_W'(CNV_CYC - 1)) begin
                    state_d = WAIT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT: begin
                bit_d = '0;
                if (tmr_q == TMR_W'(CONV_CYC - 1)) begin
                    state_d = SHIFT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            SHIFT: begin
                if (tmr_q == TMR_W'(2 * SCK_HALF - 1)) begin
                    tmr_d = '0;
                    if (bit_q == BIT_W'(B - 1)) begin
                        state_d = STORE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            STORE: begin
                if (emit_c) begin
                    pack_d = '0;
                    slot_d = '0;
                    if (i_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        rdy_d  = 1'b1;
                        data_d = word_c;
                    end
                end else begin
                    pack_d = word_c;
                    slot_d = slot_q + 1'b1;
                end
                rem_d = rem_q - 32'd1;
                idx_d = idx_q + 32'd1;
                if (rem_q == 32'd1) begin
                    fin_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (per_q >= target_c) begin
                    state_d = CNV;
                    tmr_d   = '0;
                    per_d   = 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything: drop the partial word and report completion.
        if ((state_q != IDLE) && i_stop) begin
            state_d = IDLE;
            tmr_d   = '0;
            pack_d  = '0;
            slot_d  = '0;
            data_d  = data_q;
            rdy_d   = 1'b0;
            ovf_d   = ovf_q;
            fin_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            per_q    <= '0;
            period_q <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            pack_q   <= '0;
            slot_q   <= '0;
            dbg_q    <= 1'b0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            fin_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnv_n_q  <= 1'b1;
            sck_q    <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            per_q    <= per_d;
            period_q <= period_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            pack_q   <= pack_d;
            slot_q   <= slot_d;
            dbg_q    <= dbg_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            fin_q    <= fin_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d != IDLE);
            cnv_n_q  <= (state_d != CNV);
            sck_q    <= {N_ADC{(state_d == SHIFT) && (tmr_d < TMR_W'(SCK_HALF))}};
        end
    end

    assign o_data      = data_q;
    assign o_rdy       = rdy_q;
    assign o_finished  = fin_q;
    assign o_busy      = busy_q;
    assign o_overflow  = ovf_q;
    assign o_adc_cnv_n = cnv_n_q;
    assign o_adc_sck   = sck_q;

endmodule
